ibex_prefetch_ctrl: RTL and testbench



---
 rtl/ibex_pkg.sv | 12 +
 rtl/ibex_prefetch_outstanding.sv | 60 ++++++
 rtl/ibex_prefetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_ibex_prefetch_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch slice.
// Prefetch request sequencer states and bus geometry.
package ibex_pkg;

   localparam int unsigned PF_NUM_REQS = 2;

   typedef enum logic {
      PF_IDLE = 1'b0,
      PF_HOLD = 1'b1
   } prefetch_state_e;

endpackage

// File: rtl/ibex_prefetch_outstanding.sv
// Outstanding-response tracker: thermometer vector plus per-entry discard flags.
// Bit 0 is the oldest request; responses retire from bit 0 in order.
import ibex_pkg::*;

module ibex_prefetch_outstanding #(
   parameter int unsigned NUM_REQS = PF_NUM_REQS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                gnt_i,
   input  logic                gnt_discard_i,
   input  logic                branch_i,
   input  logic                rvalid_i,
   output logic [NUM_REQS-1:0] out_o,
   output logic [NUM_REQS-1:0] discard_o
);

   logic [NUM_REQS-1:0] out_q;
   logic [NUM_REQS-1:0] disc_q;
   logic [NUM_REQS-1:0] out_s;
   logic [NUM_REQS-1:0] disc_s;
   logic [NUM_REQS-1:0] out_d;
   logic [NUM_REQS-1:0] disc_d;
   logic [NUM_REQS-1:0] slot;

   // First free slot above the occupied run of the thermometer.
   assign slot = ~out_q & ((out_q << 1) | NUM_REQS'(1));

   always_comb begin
      out_s  = out_q;
      disc_s = disc_q;
      if (branch_i) begin
         disc_s = disc_q | out_q;
      end
      if (gnt_i) begin
         out_s  = out_q | slot;
         disc_s = (disc_s & ~slot) | (gnt_discard_i ? slot : '0);
      end
      out_d  = out_s;
      disc_d = disc_s;
      if (rvalid_i && out_q[0]) begin
         out_d  = out_s >> 1;
         disc_d = disc_s >> 1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q  <= '0;
         disc_q <= '0;
      end else begin
         out_q  <= out_d;
         disc_q <= disc_d;
      end
   end

   assign out_o     = out_q;
   assign discard_o = disc_q;

endmodule

// File: rtl/ibex_prefetch_ctrl.sv
// Instruction fetch request sequencer feeding the fetch FIFO.
// Holds the bus address stable until granted and drops responses killed by branches.
import ibex_pkg::*;

module ibex_prefetch_ctrl #(
   parameter int unsigned NUM_REQS = PF_NUM_REQS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         branch_addr_i,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic [31:0]         fifo_addr_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_gnt_i,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i,
   output logic                busy_o
);

   localparam int unsigned CW = $clog2(2 * NUM_REQS + 1);

   prefetch_state_e state_q;
   prefetch_state_e state_d;

   logic [31:0]         fetch_addr_q;
   logic [31:0]         fetch_addr_d;
   logic [31:0]         stored_addr_q;
   logic [31:0]         stored_addr_d;
   logic                branch_pend_q;
   logic                branch_pend_d;
   logic [NUM_REQS-1:0] out_q;
   logic [NUM_REQS-1:0] disc_q;
   logic [CW-1:0]       used;
   logic [31:0]         branch_word;
   logic                new_req_ok;
   logic                gnt_ok;
   logic                gnt_discard;
   logic                unused_addr_bit;

   assign branch_word     = {branch_addr_i[31:2], 2'b00};
   assign unused_addr_bit = branch_addr_i[0];

   // Discarded in-flight entries never land in the FIFO, so they cost no space.
   always_comb begin
      used = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         used = used + CW'(fifo_busy_i[i]) + CW'(out_q[i] & ~disc_q[i]);
      end
   end

   assign new_req_ok = (req_i | branch_i)
                     & (branch_i | (used < CW'(NUM_REQS)))
                     & ~out_q[NUM_REQS-1];

   always_comb begin
      state_d       = state_q;
      fetch_addr_d  = fetch_addr_q;
      stored_addr_d = stored_addr_q;
      branch_pend_d = branch_pend_q;
      instr_req_o   = 1'b0;
      instr_addr_o  = fetch_addr_q;
      gnt_discard   = 1'b0;
      unique case (state_q)
         PF_IDLE: begin
            instr_req_o  = new_req_ok;
            instr_addr_o = branch_i ? branch_word : fetch_addr_q;
            if (branch_i) begin
               fetch_addr_d = branch_word;
            end
            if (new_req_ok) begin
               if (instr_gnt_i) begin
                  fetch_addr_d = instr_addr_o + 32'd4;
               end else begin
                  stored_addr_d = instr_addr_o;
                  state_d       = PF_HOLD;
               end
            end
         end
         PF_HOLD: begin
            instr_req_o  = 1'b1;
            instr_addr_o = stored_addr_q;
            gnt_discard  = branch_i | branch_pend_q;
            if (branch_i) begin
               fetch_addr_d  = branch_word;
               branch_pend_d = 1'b1;
            end
            if (instr_gnt_i) begin
               state_d       = PF_IDLE;
               branch_pend_d = 1'b0;
               if (!branch_i && !branch_pend_q) begin
                  fetch_addr_d = stored_addr_q + 32'd4;
               end
            end
         end
         default: state_d = PF_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= PF_IDLE;
         fetch_addr_q  <= '0;
         stored_addr_q <= '0;
         branch_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         stored_addr_q <= stored_addr_d;
         branch_pend_q <= branch_pend_d;
      end
   end

   assign gnt_ok = instr_req_o & instr_gnt_i;

   ibex_prefetch_outstanding #(
      .NUM_REQS (NUM_REQS)
   ) u_outstanding (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .gnt_i         (gnt_ok),
      .gnt_discard_i (gnt_discard),
      .branch_i      (branch_i),
      .rvalid_i      (instr_rvalid_i),
      .out_o         (out_q),
      .discard_o     (disc_q)
   );

   assign fifo_clear_o = branch_i;
   assign fifo_addr_o  = {branch_addr_i[31:1], 1'b0};
   assign fifo_valid_o = instr_rvalid_i & out_q[0] & ~disc_q[0] & ~branch_i;
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign busy_o       = instr_req_o | out_q[0];

   a_rvalid_outstanding: assert property (
      @(posedge clk_i) disable iff (rst_i)
      instr_rvalid_i |-> out_q[0]);

   a_addr_stable: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

   a_no_gnt_full: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (instr_req_o && instr_gnt_i) |-> !out_q[NUM_REQS-1]);

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Directed bench for the prefetch request sequencer.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_ibex_prefetch_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        req_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic [1:0]  fifo_busy_i;
   logic        fifo_clear_o;
   logic [31:0] fifo_addr_o;
   logic        fifo_valid_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_err_o;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   ibex_prefetch_ctrl #(.NUM_REQS(2)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .fifo_busy_i    (fifo_busy_i),
      .fifo_clear_o   (fifo_clear_o),
      .fifo_addr_o    (fifo_addr_o),
      .fifo_valid_o   (fifo_valid_o),
      .fifo_rdata_o   (fifo_rdata_o),
      .fifo_err_o     (fifo_err_o),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .busy_o         (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic req, input logic br, input logic [31:0] ba,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic er);
      req_i          = req;
      branch_i       = br;
      branch_addr_i  = ba;
      instr_gnt_i    = gnt;
      instr_rvalid_i = rv;
      instr_rdata_i  = rd;
      instr_err_i    = er;
      #1;
   endtask

   initial begin
      rst_i       = 1'b1;
      fifo_busy_i = 2'b00;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      check("rst_req", {31'd0, instr_req_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
      check("rst_clear", {31'd0, fifo_clear_o}, 32'd0);

      // branch to 0x1002, immediate grant
      tick();
      drive(1, 1, 32'h0000_1002, 1, 0, 0, 0);
      check("br_req", {31'd0, instr_req_o}, 32'd1);
      check("br_addr", instr_addr_o, 32'h0000_1000);
      check("br_clear", {31'd0, fifo_clear_o}, 32'd1);
      check("br_faddr", fifo_addr_o, 32'h0000_1002);
      tick();
      drive(1, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
      check("seq_addr", instr_addr_o, 32'h0000_1004);
      check("push1_v", {31'd0, fifo_valid_o}, 32'd1);
      check("push1_d", fifo_rdata_o, 32'hDEAD_BEEF);
      check("push1_e", {31'd0, fifo_err_o}, 32'd0);
      tick();
      drive(0, 0, 0, 0, 1, 32'h1111_1111, 0);
      check("push2_v", {31'd0, fifo_valid_o}, 32'd1);
      check("push2_req", {31'd0, instr_req_o}, 32'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("drain_busy", {31'd0, busy_o}, 32'd0);

      // FIFO full blocks requests, freeing one entry re-enables them
      fifo_busy_i = 2'b11;
      drive(1, 0, 0, 0, 0, 0, 0);
      check("full_req", {31'd0, instr_req_o}, 32'd0);
      fifo_busy_i = 2'b01;
      drive(1, 0, 0, 1, 0, 0, 0);
      check("part_req", {31'd0, instr_req_o}, 32'd1);
      check("part_addr", instr_addr_o, 32'h0000_1008);
      tick();
      fifo_busy_i = 2'b00;
      drive(0, 0, 0, 0, 1, 32'h2222_2222, 0);
      check("part_push", {31'd0, fifo_valid_o}, 32'd1);
      tick();

      // grant withheld at 0x2000, branch to 0x3000 while held
      drive(1, 1, 32'h0000_2000, 0, 0, 0, 0);
      check("hold_a0", instr_addr_o, 32'h0000_2000);
      tick();
      drive(1, 1, 32'h0000_3000, 0, 0, 0, 0);
      check("hold_a1", instr_addr_o, 32'h0000_2000);
      check("hold_r1", {31'd0, instr_req_o}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("hold_a2", instr_addr_o, 32'h0000_2000);
      check("hold_r2", {31'd0, instr_req_o}, 32'd1);
      tick();
      drive(0, 0, 0, 1, 0, 0, 0);
      check("hold_a3", instr_addr_o, 32'h0000_2000);
      tick();
      drive(1, 0, 0, 1, 1, 32'h5555_5555, 0);
      check("hold_drop", {31'd0, fifo_valid_o}, 32'd0);
      check("hold_next", instr_addr_o, 32'h0000_3000);
      check("hold_nreq", {31'd0, instr_req_o}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 1, 32'h3333_3333, 0);
      check("hold_push", {31'd0, fifo_valid_o}, 32'd1);
      tick();

      // two outstanding, branch kills both
      drive(1, 1, 32'h0000_0100, 1, 0, 0, 0);
      check("two_a0", instr_addr_o, 32'h0000_0100);
      tick();
      drive(1, 0, 0, 1, 0, 0, 0);
      check("two_a1", instr_addr_o, 32'h0000_0104);
      tick();
      drive(1, 1, 32'h0000_0400, 0, 1, 32'h0BAD_0100, 0);
      check("two_full", {31'd0, instr_req_o}, 32'd0);
      check("two_drop0", {31'd0, fifo_valid_o}, 32'd0);
      tick();
      drive(1, 0, 0, 1, 1, 32'h0BAD_0104, 0);
      check("two_drop1", {31'd0, fifo_valid_o}, 32'd0);
      check("two_tgt", instr_addr_o, 32'h0000_0400);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0400_DA7A, 0);
      check("two_push", {31'd0, fifo_valid_o}, 32'd1);
      check("two_data", fifo_rdata_o, 32'h0400_DA7A);
      tick();

      // bus error is forwarded and fetching continues
      drive(1, 1, 32'h0000_0200, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 1, 1, 32'hEEEE_0200, 1);
      check("err_v", {31'd0, fifo_valid_o}, 32'd1);
      check("err_e", {31'd0, fifo_err_o}, 32'd1);
      check("err_next", instr_addr_o, 32'h0000_0204);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0000_0204, 0);
      check("err_clr", {31'd0, fifo_err_o}, 32'd0);
      tick();

      // address increment wraps at the top of memory
      drive(1, 1, 32'hFFFF_FFFE, 1, 0, 0, 0);
      check("wrap_a", instr_addr_o, 32'hFFFF_FFFC);
      check("wrap_f", fifo_addr_o, 32'hFFFF_FFFE);
      tick();
      drive(0, 0, 0, 0, 1, 32'h7777_7777, 0);
      check("wrap_n", instr_addr_o, 32'h0000_0000);
      tick();

      // reset with two outstanding
      drive(1, 1, 32'h0000_0500, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 1, 0, 0, 0);
      tick();
      rst_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0BAD_0500, 0);
      check("rst2_busy", {31'd0, busy_o}, 32'd0);
      check("rst2_drop", {31'd0, fifo_valid_o}, 32'd0);
      tick();
      rst_i = 1'b0;
      drive(1, 0, 0, 1, 0, 0, 0);
      check("rst2_addr", instr_addr_o, 32'h0000_0000);
      check("rst2_req", {31'd0, instr_req_o}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0000_0000, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
